axi4lite_regfile_slave: RTL and testbench

AXI4-Lite slave register file that sits directly downstream of the `axi4lite_top` master and terminates its write and read transactions. It holds `2**ADDR_WIDTH` registers of `DATA_WIDTH` bits. The top-most address is a read-only status register fed from fabric; the rest are read/write control registers exported to fabric. Write-address and write-data channels are accepted independently, responses are fully registered, and back-pressure on B/R is honoured.

---
 rtl/axi4lite_regfile_slave.sv | 134 +++++++++++++
 tb/tb_axi4lite_regfile_slave.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave register file: N-1 read/write control registers plus a read-only status register at N-1.
// Define AXI4LITE_SLV_ERR_EN to answer writes to the status address with SLVERR instead of OKAY.
module axi4lite_regfile_slave #(
   parameter int                    ADDR_WIDTH = 2,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic [ADDR_WIDTH-1:0]                   awaddr,
   input  logic                                    awvalid,
   output logic                                    awready,
   input  logic [DATA_WIDTH-1:0]                   wdata,
   input  logic                                    wvalid,
   output logic                                    wready,
   output logic [1:0]                              bresp,
   output logic                                    bvalid,
   input  logic                                    bready,
   input  logic [ADDR_WIDTH-1:0]                   araddr,
   input  logic                                    arvalid,
   output logic                                    arready,
   output logic [DATA_WIDTH-1:0]                   rdata,
   output logic [1:0]                              rresp,
   output logic                                    rvalid,
   input  logic                                    rready,
   input  logic [DATA_WIDTH-1:0]                   status_in,
   output logic [(2**ADDR_WIDTH-1)*DATA_WIDTH-1:0] regs_out
);

   localparam int                    N           = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = '1;

   logic                  aw_held;
   logic [ADDR_WIDTH-1:0] aw_addr_q;
   logic                  w_held;
   logic [DATA_WIDTH-1:0] w_data_q;
   logic [DATA_WIDTH-1:0] regs [0:N-2];

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;
   logic [ADDR_WIDTH-1:0] commit_addr;
   logic [DATA_WIDTH-1:0] commit_data;
   logic                  commit_to_status;
   logic [1:0]            wr_resp;
   logic [DATA_WIDTH-1:0] rd_sel;

   assign awready = !aw_held && !bvalid;
   assign wready  = !w_held && !bvalid;
   assign arready = !rvalid;
   assign rresp   = 2'b00;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;

   // A write commits on the edge where the later of the two channels arrives; the
   // earlier one is taken from its latch, the one arriving now straight off the bus.
   assign commit           = (aw_hs || aw_held) && (w_hs || w_held);
   assign commit_addr      = aw_hs ? awaddr : aw_addr_q;
   assign commit_data      = w_hs ? wdata : w_data_q;
   assign commit_to_status = (commit_addr == STATUS_ADDR);

`ifdef AXI4LITE_SLV_ERR_EN
   assign wr_resp = commit_to_status ? 2'b10 : 2'b00;
`else
   assign wr_resp = 2'b00;
`endif

   // NOTE: combinational blocks assign a default first so no path leaves rd_sel unassigned (no latch).
   always_comb begin
      rd_sel = status_in;
      for (int i = 0; i < N-1; i++) begin
         if (araddr == ADDR_WIDTH'(i)) rd_sel = regs[i];
      end
   end

   // Write address/data capture and write response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         aw_held   <= 1'b0;
         aw_addr_q <= '0;
         w_held    <= 1'b0;
         w_data_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= 2'b00;
      end else if (commit) begin
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bvalid  <= 1'b1;
         bresp   <= wr_resp;
      end else begin
         if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= awaddr;
         end
         if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= wdata;
         end
         if (bvalid && bready) bvalid <= 1'b0;
      end
   end

   // NOTE: the register array is small control state that fabric sees at reset, so every entry is reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N-1; i++) regs[i] <= RESET_VAL;
      end else if (commit && !commit_to_status) begin
         for (int i = 0; i < N-1; i++) begin
            if (commit_addr == ADDR_WIDTH'(i)) regs[i] <= commit_data;
         end
      end
   end

   // NOTE: non-blocking updates make a same-edge read see the register value from before the write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= rd_sel;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

   for (genvar g = 0; g < N-1; g++) begin : g_regs_out
      assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Self-checking bench for axi4lite_regfile_slave: directed cases then randomized writes/reads
// against an array model of the register file.
module tb_axi4lite_regfile_slave;

   localparam int AW = 2;
   localparam int DW = 8;
   localparam int N  = 2**AW;
   localparam logic [AW-1:0] STATUS_ADDR = AW'(N-1);
`ifdef AXI4LITE_SLV_ERR_EN
   localparam logic [1:0] STATUS_WR_RESP = 2'b10;
`else
   localparam logic [1:0] STATUS_WR_RESP = 2'b00;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic [AW-1:0]     awaddr;
   logic              awvalid;
   logic              awready;
   logic [DW-1:0]     wdata;
   logic              wvalid;
   logic              wready;
   logic [1:0]        bresp;
   logic              bvalid;
   logic              bready;
   logic [AW-1:0]     araddr;
   logic              arvalid;
   logic              arready;
   logic [DW-1:0]     rdata;
   logic [1:0]        rresp;
   logic              rvalid;
   logic              rready;
   logic [DW-1:0]     status_in;
   logic [(N-1)*DW-1:0] regs_out;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] mregs [N-1];

   axi4lite_regfile_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_VAL('0)) dut (
      .clk(clk), .rst_n(rst_n),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .status_in(status_in), .regs_out(regs_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge: sample outputs and drive inputs there.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [(N-1)*DW-1:0] model_pack();
      logic [(N-1)*DW-1:0] v = '0;
      for (int i = 0; i < N-1; i++) v[i*DW +: DW] = mregs[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N-1; i++) mregs[i] = '0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awready"}, 32'(awready), 32'd1);
      check({tag, "_wready"},  32'(wready),  32'd1);
      check({tag, "_arready"}, 32'(arready), 32'd1);
      check({tag, "_bvalid"},  32'(bvalid),  32'd0);
      check({tag, "_rvalid"},  32'(rvalid),  32'd0);
      check({tag, "_bresp"},   32'(bresp),   32'd0);
      check({tag, "_rresp"},   32'(rresp),   32'd0);
      check({tag, "_rdata"},   32'(rdata),   32'd0);
      check({tag, "_regs"},    32'(regs_out), 32'(model_pack()));
   endtask

   // order: 0 = AW and W together, 1 = W first, 2 = AW first; gap = idle cycles between them;
   // bdelay = cycles bready is held low once bvalid rises.
   task automatic write_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input int order, input int gap, input int bdelay);
      logic [1:0] exp_resp = (addr == STATUS_ADDR) ? STATUS_WR_RESP : 2'b00;
      bready = (bdelay == 0);
      awaddr = addr;
      wdata  = data;
      check("wr_awready_open", 32'(awready), 32'd1);
      check("wr_wready_open",  32'(wready),  32'd1);
      if (order == 0) begin
         awvalid = 1'b1; wvalid = 1'b1;
         tick();
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         if (order == 1) wvalid = 1'b1; else awvalid = 1'b1;
         tick();
         wvalid = 1'b0; awvalid = 1'b0;
         for (int i = 0; i <= gap; i++) begin
            if (order == 1) check("wr_wready_held", 32'(wready), 32'd0);
            else            check("wr_awready_held", 32'(awready), 32'd0);
            check("wr_no_early_commit", 32'(bvalid), 32'd0);
            if (i < gap) tick();
         end
         if (order == 1) awvalid = 1'b1; else wvalid = 1'b1;
         tick();
         wvalid = 1'b0; awvalid = 1'b0;
      end
      if (addr != STATUS_ADDR) mregs[addr] = data;
      check("wr_bvalid", 32'(bvalid), 32'd1);
      check("wr_bresp",  32'(bresp),  32'(exp_resp));
      check("wr_regs_out", 32'(regs_out), 32'(model_pack()));
      for (int i = 0; i < bdelay; i++) begin
         tick();
         check("wr_bvalid_stall", 32'(bvalid), 32'd1);
         check("wr_bresp_stall",  32'(bresp),  32'(exp_resp));
         check("wr_awready_stall", 32'(awready), 32'd0);
         check("wr_wready_stall",  32'(wready),  32'd0);
      end
      bready = 1'b1;
      tick();
      check("wr_bvalid_clear", 32'(bvalid), 32'd0);
      check("wr_awready_reopen", 32'(awready), 32'd1);
   endtask

   task automatic read_txn(input logic [AW-1:0] addr, input int rdelay);
      logic [DW-1:0] exp_data = (addr == STATUS_ADDR) ? status_in : mregs[addr];
      rready = (rdelay == 0);
      araddr = addr;
      check("rd_arready_open", 32'(arready), 32'd1);
      arvalid = 1'b1;
      tick();
      arvalid = 1'b0;
      check("rd_rvalid", 32'(rvalid), 32'd1);
      check("rd_rdata",  32'(rdata),  32'(exp_data));
      check("rd_rresp",  32'(rresp),  32'd0);
      for (int i = 0; i < rdelay; i++) begin
         tick();
         check("rd_rvalid_stall",  32'(rvalid),  32'd1);
         check("rd_rdata_stall",   32'(rdata),   32'(exp_data));
         check("rd_arready_stall", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      tick();
      check("rd_rvalid_clear", 32'(rvalid), 32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b1;
      araddr = '0; arvalid = 1'b0; rready = 1'b1; status_in = '0;
      model_reset();

      // Power-on reset.
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();

      // AW and W together, then read back.
      write_txn(2'd2, 8'h04, 0, 0, 0);
      check("reg2_slice", 32'(regs_out[23:16]), 32'h04);
      read_txn(2'd2, 0);

      // W three cycles ahead of AW.
      write_txn(2'd1, 8'hA5, 1, 2, 0);
      check("reg1_slice", 32'(regs_out[15:8]), 32'hA5);

      // Back-pressure on B and R.
      write_txn(2'd0, 8'h11, 0, 0, 4);
      read_txn(2'd0, 4);

      // Status register: writes ignored, reads return status_in.
      status_in = 8'h5C;
      write_txn(STATUS_ADDR, 8'hFF, 0, 0, 0);
      read_txn(STATUS_ADDR, 0);

      // Same-edge write and read of register 0 returns the old value.
      awaddr = 2'd0; wdata = 8'h33; araddr = 2'd0;
      awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
      tick();
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      check("same_edge_rdata", 32'(rdata), 32'h11);
      check("same_edge_bvalid", 32'(bvalid), 32'd1);
      mregs[0] = 8'h33;
      tick();
      read_txn(2'd0, 0);

      // Reset pulse with W held and a read response pending.
      wdata = 8'h77; wvalid = 1'b1; araddr = 2'd1; arvalid = 1'b1; rready = 1'b0;
      tick();
      wvalid = 1'b0; arvalid = 1'b0;
      check("pre_rst_wready", 32'(wready), 32'd0);
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      rst_n = 1'b0;
      model_reset();
      #1 check_reset_outputs("mid_reset");
      #1 rst_n = 1'b1;
      rready = 1'b1;
      tick();
      write_txn(2'd1, 8'h5A, 2, 1, 0);
      read_txn(2'd1, 0);

      // Randomized traffic against the model.
      for (int it = 0; it < 60; it++) begin
         status_in = DW'($urandom);
         if ($urandom_range(0, 1) == 0)
            write_txn(AW'($urandom_range(0, N-1)), DW'($urandom), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            read_txn(AW'($urandom_range(0, N-1)), int'($urandom_range(0, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
